// File: rtl/p2s_lane_tx_if.sv
// rtl/p2s_lane_tx_if.sv - word handshake and serial lane bundle for p2s_lane_tx
interface p2s_lane_tx_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                   i_enb;
    logic                   i_dir;
    logic [LANES*WIDTH-1:0] i_d_in;
    logic                   i_valid;
    logic                   o_ready;
    logic [LANES-1:0]       o_s_out;
    logic                   o_frame;

    modport master (
        output i_enb, i_dir, i_d_in, i_valid,
        input  o_ready, o_s_out, o_frame
    );

    modport slave (
        input  i_enb, i_dir, i_d_in, i_valid,
        output o_ready, o_s_out, o_frame
    );
endinterface

// File: rtl/p2s_lane_tx.sv
// rtl/p2s_lane_tx.sv - multi-lane parallel-to-serial transmitter with one-word holding buffer
// Optional feature macro: P2S_PARITY_EN (appends one even-parity bit per lane per word).
module p2s_lane_tx #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    p2s_lane_tx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef P2S_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t                         r_state;
    logic [LANES-1:0][WIDTH-1:0]    r_hold;
    logic [LANES-1:0][WIDTH-1:0]    r_shift;
    logic                           r_hold_full;
    logic                           r_dir;
    logic [CW-1:0]                  r_cnt;
    logic [LANES-1:0]               r_fill;

    logic                           w_accept;
    logic                           w_last;
    logic                           w_load;
    logic [LANES-1:0]               w_par;
    logic [LANES-1:0]               w_s_out;

    assign bus.o_ready = bus.i_enb & ~r_hold_full;
    assign w_accept    = bus.i_enb & bus.i_valid & ~r_hold_full;
    assign w_last      = (r_cnt == CW'(LAST));
    assign w_load      = r_hold_full & ((r_state == ST_IDLE) | w_last);

    // The shift fill bit becomes the output bit once all data bits have gone out.
`ifdef P2S_PARITY_EN
    always_comb begin
        w_par = '0;
        for (int k = 0; k < LANES; k++) w_par[k] = ^r_hold[k];
    end
`else
    assign w_par = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_shift     <= '0;
            r_hold_full <= 1'b0;
            r_dir       <= 1'b1;
            r_cnt       <= '0;
            r_fill      <= '0;
        end else if (bus.i_enb) begin
            if (w_load) begin
                r_shift     <= r_hold;
                r_dir       <= bus.i_dir;
                r_fill      <= w_par;
                r_hold_full <= 1'b0;
                r_cnt       <= '0;
                r_state     <= ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    for (int k = 0; k < LANES; k++) begin
                        r_shift[k] <= r_dir ? {r_shift[k][WIDTH-2:0], r_fill[k]}
                                            : {r_fill[k], r_shift[k][WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            // Accept needs an empty buffer and load needs a full one, so they never collide.
            if (w_accept) begin
                r_hold      <= bus.i_d_in;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_comb begin
        w_s_out = '0;
        if (r_state == ST_SHIFT) begin
            for (int k = 0; k < LANES; k++)
                w_s_out[k] = r_dir ? r_shift[k][WIDTH-1] : r_shift[k][0];
        end
    end

    assign bus.o_s_out = w_s_out;
    assign bus.o_frame = (r_state == ST_SHIFT);
endmodule

// File: tb/tb_p2s_lane_tx.sv
// tb/tb_p2s_lane_tx.sv - randomized and directed bench for p2s_lane_tx against a word-level model
module tb_p2s_lane_tx;
    localparam int W = 8;
    localparam int L = 4;
`ifdef P2S_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    p2s_lane_tx_if #(.WIDTH(W), .LANES(L)) bus ();
    p2s_lane_tx #(.WIDTH(W), .LANES(L)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // word-level model: holding slot plus the word currently on the wire
    logic          m_hf;
    logic [31:0]   m_hold;
    logic [31:0]   m_cur;
    logic          m_dir;
    int            m_pos;
    logic          m_busy;

    logic [L-1:0]  cap [16];
    int            ncap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hf = 0; m_hold = '0; m_cur = '0; m_dir = 1; m_pos = 0; m_busy = 0;
    endtask

    function automatic logic [L-1:0] exp_sout();
        logic [L-1:0] s;
        logic [W-1:0] lw;
        s = '0;
        if (m_busy) begin
            for (int k = 0; k < L; k++) begin
                lw = m_cur[k*W +: W];
                if (m_pos >= W) s[k] = ^lw;
                else            s[k] = m_dir ? lw[W-1-m_pos] : lw[m_pos];
            end
        end
        return s;
    endfunction

    task automatic model_edge();
        logic acc;
        if (!bus.i_enb) return;
        acc = bus.i_valid && !m_hf;
        if (m_busy && m_pos != NB-1) begin
            m_pos++;
        end else if (m_hf) begin
            m_cur = m_hold; m_dir = bus.i_dir; m_pos = 0; m_busy = 1; m_hf = 0;
        end else begin
            m_busy = 0;
        end
        if (acc) begin
            m_hold = bus.i_d_in;
            m_hf = 1;
        end
    endtask

    task automatic step();
        #1;
        chk("ready", {31'd0, bus.o_ready}, {31'd0, bus.i_enb & ~m_hf});
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        chk("frame", {31'd0, bus.o_frame}, {31'd0, m_busy});
        chk("s_out", {28'd0, bus.o_s_out}, {28'd0, exp_sout()});
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_frame", {31'd0, bus.o_frame}, 32'd0);
        chk("rst_s_out", {28'd0, bus.o_s_out}, 32'd0);
        chk("rst_ready", {31'd0, bus.o_ready}, {31'd0, bus.i_enb});
        step();
        rst = 1'b0;
    endtask

    task automatic run_word(input logic [31:0] w, input logic d, input int tog_at);
        bus.i_enb = 1; bus.i_valid = 1; bus.i_d_in = w; bus.i_dir = d;
        step();
        bus.i_valid = 0;
        ncap = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.o_frame) begin
                if (ncap < 16) cap[ncap] = bus.o_s_out;
                ncap++;
                if (ncap == tog_at) bus.i_dir = ~bus.i_dir;
            end else if (ncap > 0) begin
                break;
            end
        end
        chk("word_frames", ncap, NB);
    endtask

    function automatic logic [15:0] lane_seq(input int l);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < ncap && i < 16; i++) s = {s[14:0], cap[i][l]};
        return s;
    endfunction

    logic [31:0] words [3];
    int idx, nf, first, last;
    logic acc;

    initial begin
        bus.i_enb = 1; bus.i_dir = 1; bus.i_valid = 0; bus.i_d_in = '0;
        model_reset();
        #23;
        chk("reset_frame", {31'd0, bus.o_frame}, 32'd0);
        chk("reset_s_out", {28'd0, bus.o_s_out}, 32'd0);
        chk("reset_ready", {31'd0, bus.o_ready}, 32'd1);
        rst = 1'b0;
        step();

        // MSB first
        run_word(32'hA53C0FF0, 1'b1, 0);
`ifdef P2S_PARITY_EN
        chk("msb_lane0", lane_seq(0), 16'h01E0);
        chk("msb_lane3", lane_seq(3), 16'h014A);
`else
        chk("msb_lane0", lane_seq(0), 16'h00F0);
        chk("msb_lane3", lane_seq(3), 16'h00A5);
`endif
        // LSB first with DIR toggled mid-word
        run_word(32'hA53C0FF0, 1'b0, 4);
`ifdef P2S_PARITY_EN
        chk("lsb_lane0", lane_seq(0), 16'h001E);
        chk("lsb_lane1", lane_seq(1), 16'h01E0);
        run_word(32'h00000007, 1'b1, 0);
        chk("par_lane0", lane_seq(0), 16'h000F);
`else
        chk("lsb_lane0", lane_seq(0), 16'h000F);
        chk("lsb_lane1", lane_seq(1), 16'h00F0);
`endif

        // back-to-back words with VALID held high
        words[0] = 32'h01010101; words[1] = 32'h80808080; words[2] = 32'hFFFFFFFF;
        bus.i_dir = 1; idx = 0; nf = 0; first = -1; last = -1;
        for (int c = 0; c < 80; c++) begin
            bus.i_valid = (idx < 3);
            bus.i_d_in  = words[idx < 3 ? idx : 2];
            acc = bus.i_valid && !m_hf;
            step();
            if (acc) idx++;
            if (bus.o_frame) begin
                nf++; last = c;
                if (first < 0) first = c;
            end else if (idx == 3 && nf > 0) begin
                break;
            end
        end
        bus.i_valid = 0;
        chk("b2b_words", idx, 3);
        chk("b2b_frames", nf, 3*NB);
        chk("b2b_nogap", last - first + 1, nf);

        // ENB low for three cycles at bit 5
        bus.i_valid = 1; bus.i_d_in = 32'h5A96C3E1; bus.i_dir = 0;
        step();
        bus.i_valid = 0;
        for (int i = 0; i < 20 && !(m_busy && m_pos == 5); i++) step();
        chk("enb_reach_bit5", m_pos, 5);
        bus.i_enb = 0;
        for (int i = 0; i < 3; i++) step();
        bus.i_enb = 1;
        for (int i = 0; i < 12; i++) step();
        chk("enb_done", {31'd0, bus.o_frame}, 32'd0);

        // async reset at bit 3
        bus.i_valid = 1; bus.i_d_in = 32'hDEADBEEF; bus.i_dir = 1;
        step();
        bus.i_valid = 0;
        for (int i = 0; i < 20 && !(m_busy && m_pos == 3); i++) step();
        async_reset_pulse();
        for (int i = 0; i < 12; i++) step();

        // randomized traffic with occasional async reset
        for (int i = 0; i < 600; i++) begin
            bus.i_enb   = ($urandom % 8) != 0;
            bus.i_valid = $urandom % 2;
            bus.i_dir   = $urandom % 2;
            bus.i_d_in  = $urandom;
            if (($urandom % 100) == 0) async_reset_pulse();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
